// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Optional signed support is enabled with DIV_SIGNED_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_XLEN = 32;

  localparam logic [DIV_XLEN-1:0] DIV_BY0_Q = '1;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the execute unit and the divider.
// Carries signed_i only when DIV_SIGNED_EN is defined.
interface div_if #(
  parameter int XLEN = 32
);

  logic            req_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            ready_o;
  logic [XLEN-1:0] quotient_o;
  logic [XLEN-1:0] remainder_o;
`ifdef DIV_SIGNED_EN
  logic            signed_i;
`endif

  modport master (
    output req_i, a_i, b_i,
    input  ready_o, quotient_o, remainder_o
`ifdef DIV_SIGNED_EN
    , output signed_i
`endif
  );

  modport slave (
    input  req_i, a_i, b_i,
    output ready_o, quotient_o, remainder_o
`ifdef DIV_SIGNED_EN
    , input signed_i
`endif
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem,quo} pair.
// The subtract is one bit wider so its MSB is the borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] sh;
  logic [XLEN:0] trial;

  assign sh    = {rem_i, quo_i[XLEN-1]};
  assign trial = sh - {1'b0, dvs_i};

  // rem < dvs always, so the kept value fits in XLEN bits
  assign rem_o = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider, XLEN steps per operation.
// Define DIV_SIGNED_EN to add two's-complement operands via signed_i.
module div
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic clk_i,
  input  logic rst_ni,
  div_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            ready_q;
  logic [XLEN-1:0] quo_out_q;
  logic [XLEN-1:0] rem_out_q;
  logic            negq_q;
  logic            negr_q;

  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

`ifdef DIV_SIGNED_EN
  assign a_neg = bus.signed_i & bus.a_i[XLEN-1];
  assign b_neg = bus.signed_i & bus.b_i[XLEN-1];
  assign a_mag = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag = b_neg ? -bus.b_i : bus.b_i;
  assign q_fin = negq_q ? -quo_d : quo_d;
  assign r_fin = negr_q ? -rem_d : rem_d;
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = bus.a_i;
  assign b_mag = bus.b_i;
  assign q_fin = quo_d;
  assign r_fin = rem_d;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      ready_q   <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.req_i) begin
            if (bus.b_i == '0) begin
              quo_out_q <= DIV_BY0_Q[XLEN-1:0];
              rem_out_q <= bus.a_i;
              state_q   <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!bus.req_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              quo_out_q <= q_fin;
              rem_out_q <= r_fin;
              cnt_q     <= '0;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          // ready follows req one edge later, giving XLEN+1 total latency
          ready_q <= bus.req_i;
          if (!bus.req_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.quotient_o  = quo_out_q;
  assign bus.remainder_o = rem_out_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: directed vectors, decoupled monitor.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic rdy_prev = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          at;
  } exp_t;

  exp_t sb[$];

  div_if #(.XLEN(32)) bus ();

  div #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every rising ready_o must match the oldest expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_prev = 1'b0;
    end else begin
      if (bus.ready_o && !rdy_prev) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ready: got ready at cycle %0d want none",
                   cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", bus.quotient_o, e.q);
          chk("remainder", bus.remainder_o, e.r);
          chk("latency", 32'(cyc), 32'(e.at));
        end
      end
      rdy_prev = bus.ready_o;
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er,
                    input int lat);
    exp_t e;
    int k;
    @(negedge clk);
    bus.a_i   = a;
    bus.b_i   = b;
    bus.req_i = 1'b1;
    e.q  = eq;
    e.r  = er;
    e.at = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.a_i = ~a;
    bus.b_i = 32'd1;
    k = 0;
    while (!bus.ready_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ready_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got no ready within 60 cycles want ready");
    end
    @(negedge clk);
    chk("ready_hold", 32'(bus.ready_o), 32'd1);
    bus.req_i = 1'b0;
    @(negedge clk);
    chk("ready_drop", 32'(bus.ready_o), 32'd0);
  endtask

  initial begin
    bus.req_i = 1'b0;
    bus.a_i   = '0;
    bus.b_i   = '0;
`ifdef DIV_SIGNED_EN
    bus.signed_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_quot", bus.quotient_o, 32'd0);
    chk("rst_rem", bus.remainder_o, 32'd0);
    rst_n = 1'b1;

    op(32'd100, 32'd7, 32'd14, 32'd2, 33);
    op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    op(32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 33);

    // abort mid-operation; monitor flags any ready_o
    @(negedge clk);
    bus.a_i   = 32'd1000;
    bus.b_i   = 32'd3;
    bus.req_i = 1'b1;
    repeat (10) @(negedge clk);
    bus.req_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_ready", 32'(bus.ready_o), 32'd0);
    op(32'd20, 32'd4, 32'd5, 32'd0, 33);

    // asynchronous reset between edges while busy
    @(negedge clk);
    bus.a_i   = 32'd50;
    bus.b_i   = 32'd3;
    bus.req_i = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready_o), 32'd0);
    chk("mid_rst_quot", bus.quotient_o, 32'd0);
    chk("mid_rst_rem", bus.remainder_o, 32'd0);
    bus.req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(32'd9, 32'd2, 32'd4, 32'd1, 33);

`ifdef DIV_SIGNED_EN
    bus.signed_i = 1'b1;
    op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    op(32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
    bus.signed_i = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
